// File: rtl/mux_4x1_rr_arbiter_if.sv
// Requester-side bundle for the shared 4:1 mux: request vector in, grant/select/enable out.
interface mux_4x1_rr_arbiter_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       S1;
    logic       S0;
    logic       E;
    logic       busy;

    modport master (output req, input gnt, S1, S0, E, busy);
    modport slave  (input req, output gnt, S1, S0, E, busy);
endinterface

// File: rtl/mux_4x1_rr_arbiter.sv
// Round-robin owner of a decoder/tri-state 4:1 mux with bounded tenure.
// Define MUX_4X1_ARB_TURNAROUND_EN to insert one dead cycle (TURN) between grants.
module mux_4x1_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned HOLD_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    mux_4x1_rr_arbiter_if.slave     bus
);

`ifdef MUX_4X1_ARB_TURNAROUND_EN
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, TURN = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1} state_t;
`endif

    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
    // With unlimited tenure the counter just parks at all-ones.
    localparam logic [HOLD_W-1:0] CNT_SAT  = (MAX_HOLD == 0) ? {HOLD_W{1'b1}} : HOLD_LIM;

    state_t            state_q, state_d;
    logic [1:0]        cur_q, cur_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic [3:0]        gnt_q, gnt_d;
    logic [1:0]        sel_q, sel_d;
    logic              e_q, e_d;

    logic [3:0]        req;
    logic [3:0]        cur_oh;
    logic [3:0]        others;
    logic              hold_hit;
    logic              grant_end;

    // First set bit of r scanning p, p+1, ... mod 4.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        pick = p;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) pick = idx;
        end
    endfunction

    assign req       = bus.req;
    assign cur_oh    = 4'b0001 << cur_q;
    assign others    = req & ~cur_oh;
    assign hold_hit  = (MAX_HOLD != 0) && (cnt_q == HOLD_LIM);
    assign grant_end = !req[cur_q] || (hold_hit && (others != 4'b0000));

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req != 4'b0000) begin
                    state_d = GRANT;
                    cur_d   = pick(req, ptr_q);
                    cnt_d   = HOLD_W'(1);
                end
            end
            GRANT: begin
                if (grant_end) begin
                    ptr_d = cur_q + 2'd1;
`ifdef MUX_4X1_ARB_TURNAROUND_EN
                    state_d = TURN;
                    cnt_d   = '0;
`else
                    // Scanning from cur+1 reaches every other requester before cur itself.
                    if (others != 4'b0000) begin
                        state_d = GRANT;
                        cur_d   = pick(others, cur_q + 2'd1);
                        cnt_d   = HOLD_W'(1);
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
`endif
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + HOLD_W'(1);
                end
            end
`ifdef MUX_4X1_ARB_TURNAROUND_EN
            TURN: begin
                if (req != 4'b0000) begin
                    state_d = GRANT;
                    cur_d   = pick(req, ptr_q);
                    cnt_d   = HOLD_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from next state and registered; select holds outside GRANT.
        e_d   = (state_d == GRANT);
        gnt_d = e_d ? (4'b0001 << cur_d) : 4'b0000;
        sel_d = cur_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= 2'd0;
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            e_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            e_q     <= e_d;
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.S1   = sel_q[1];
    assign bus.S0   = sel_q[0];
    assign bus.E    = e_q;
    assign bus.busy = e_q;

endmodule

// File: tb/tb_mux_4x1_rr_arbiter.sv
// Directed bench: owner/tenure model checked every cycle, plus literal pins on key cycles.
module tb_mux_4x1_rr_arbiter;
    localparam int MAXH = 4;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    mux_4x1_rr_arbiter_if bus ();

    mux_4x1_rr_arbiter #(.MAX_HOLD(MAXH), .HOLD_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model: who owns the bus, for how many cycles, and where the scan starts next.
    int   m_owner;
    int   m_held;
    int   m_ptr;
    int   m_sel;
    bit   m_valid;

    function automatic int first_req(input logic [3:0] r, input int from);
        for (int k = 0; k < 4; k++)
            if (r[(from + k) % 4]) return (from + k) % 4;
        return -1;
    endfunction

    always @(posedge clk) begin : model
        int   o, h, p, s, w;
        logic [3:0] r;
        bit   done;
        r = bus.req;
        o = m_owner; h = m_held; p = m_ptr; s = m_sel;
        if (rst) begin
            o = -1; h = 0; p = 0; s = 0;
        end else if (o >= 0) begin
            done = !r[o] || (MAXH != 0 && h >= MAXH && (r & ~(4'b0001 << o)) != 4'b0000);
            if (done) begin
                p = (o + 1) % 4;
`ifdef MUX_4X1_ARB_TURNAROUND_EN
                o = -1;
                h = -1;   // marks the dead cycle; the next edge may grant
`else
                w = first_req(r & ~(4'b0001 << o), p);
                o = w;
                h = 1;
                if (w >= 0) s = w;
`endif
            end else begin
                h = h + 1;
            end
        end else begin
            w = first_req(r, p);
            if (w >= 0) begin
                o = w; h = 1; s = w;
            end
        end
        m_owner <= o;
        m_held  <= h;
        m_ptr   <= p;
        m_sel   <= s;
        if (rst) m_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_gnt",  int'(bus.gnt), (m_owner >= 0) ? (1 << m_owner) : 0);
            check("model_E",    int'(bus.E),    (m_owner >= 0) ? 1 : 0);
            check("model_busy", int'(bus.busy), (m_owner >= 0) ? 1 : 0);
            check("model_sel",  int'({bus.S1, bus.S0}), m_sel);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int order [5] = '{0, 1, 2, 3, 0};

    initial begin
        n_cmp = 0; n_bad = 0;
        m_owner = -1; m_held = 0; m_ptr = 0; m_sel = 0; m_valid = 1'b0;
        rst = 1'b1;
        bus.req = 4'b0000;
        tick(); tick();
        check("reset_gnt", int'(bus.gnt), 0);
        check("reset_E", int'(bus.E), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_sel", int'({bus.S1, bus.S0}), 0);

        // Single request, 1-cycle latency, drop returns to idle with select held.
        rst = 1'b0;
        bus.req = 4'b0100;
        tick();
        check("single_gnt", int'(bus.gnt), 4'b0100);
        check("single_sel", int'({bus.S1, bus.S0}), 2);
        check("single_E", int'(bus.E), 1);
        bus.req = 4'b0000;
        tick();
        check("drop_gnt", int'(bus.gnt), 0);
        check("drop_E", int'(bus.E), 0);
        check("drop_sel_hold", int'({bus.S1, bus.S0}), 2);

        // Fairness: all request, each releases after 3 granted cycles.
        rst = 1'b1; tick(); rst = 1'b0;
        bus.req = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            check("rr_gnt", int'(bus.gnt), 1 << order[k]);
            check("rr_sel", int'({bus.S1, bus.S0}), order[k]);
            tick(); tick();
            bus.req = 4'b1111 & ~(4'b0001 << order[k]);
            tick();
            bus.req = 4'b1111;
        end
        check("rr_after", int'(bus.gnt), 4'b0010);
        bus.req = 4'b0000;
        tick();

        // Preemption at MAX_HOLD=4.
        rst = 1'b1; tick(); rst = 1'b0;
        bus.req = 4'b0001;
        tick();
        check("pre_c1", int'(bus.gnt), 4'b0001);
        bus.req = 4'b0101;
        tick(); check("pre_c2", int'(bus.gnt), 4'b0001);
        tick(); check("pre_c3", int'(bus.gnt), 4'b0001);
        tick(); check("pre_c4", int'(bus.gnt), 4'b0001);
        tick();
`ifdef MUX_4X1_ARB_TURNAROUND_EN
        check("pre_turn", int'(bus.gnt), 0);
        tick();
`endif
        check("pre_switch", int'(bus.gnt), 4'b0100);
        tick();
        bus.req = 4'b0001;
        tick();
`ifdef MUX_4X1_ARB_TURNAROUND_EN
        tick();
`endif
        check("pre_regrant0", int'(bus.gnt), 4'b0001);
        bus.req = 4'b0000;
        tick();

        // Saturation: lone requester never preempted.
        rst = 1'b1; tick(); rst = 1'b0;
        bus.req = 4'b0010;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("sat_gnt", int'(bus.gnt), 4'b0010);
        end
        bus.req = 4'b0000;
        tick();

        // Mid-grant reset clears pointer.
        rst = 1'b1; tick(); rst = 1'b0;
        bus.req = 4'b1000;
        tick();
        check("mid_gnt", int'(bus.gnt), 4'b1000);
        rst = 1'b1;
        tick();
        check("mid_rst_gnt", int'(bus.gnt), 0);
        check("mid_rst_E", int'(bus.E), 0);
        check("mid_rst_sel", int'({bus.S1, bus.S0}), 0);
        rst = 1'b0;
        bus.req = 4'b1001;
        tick();
        check("mid_first0", int'(bus.gnt), 4'b0001);
        bus.req = 4'b0000;
        tick();

        // Handover 0 -> 1.
        rst = 1'b1; tick(); rst = 1'b0;
        bus.req = 4'b0011;
        tick();
        check("ho_gnt0", int'(bus.gnt), 4'b0001);
        bus.req = 4'b0010;
        tick();
`ifdef MUX_4X1_ARB_TURNAROUND_EN
        check("ho_dead_gnt", int'(bus.gnt), 0);
        check("ho_dead_E", int'(bus.E), 0);
        check("ho_dead_sel", int'({bus.S1, bus.S0}), 0);
        tick();
`endif
        check("ho_gnt1", int'(bus.gnt), 4'b0010);
        bus.req = 4'b0000;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mux_4x1_rr_arbiter.md
Name: mux_4x1_rr_arbiter

Overview:
- Round-robin controller that shares one 4:1 multiplexer among four requesters. The multiplexer is built from a 2:4 decoder driving tri-state buffers.
- Drives the mux select lines S1/S0 and the decoder enable, and returns a one-hot grant to each requester.
- Bounds bus tenure with a programmable hold limit, so no requester can starve the others.
- Sits between the requester logic and the mux datapath; the datapath itself is unchanged.

Parameters:
- MAX_HOLD, 8, maximum consecutive grant cycles while others wait; 0 = unlimited tenure.
- HOLD_W, 8, hold-counter width; MAX_HOLD must be < 2^HOLD_W.

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  req[i]=1: requester i wants input I[i] routed to Y; held high for the whole transfer.
- gnt  output 4  one-hot grant; gnt[i]=1 while I[i] is selected and enabled.
- S1   output 1  mux select MSB (decoder input).
- S0   output 1  mux select LSB (decoder input).
- E    output 1  decoder enable; 0 = all tri-state buffers off (Y floats).
- busy output 1  1 while any grant is active.

Behaviour:
- Reset (sync, active-high, any time, including mid-grant):
  - Next edge: state=IDLE, gnt=0000, S1=0, S0=0, E=0, busy=0.
  - Priority pointer ptr=0; hold counter cnt=0.
- States: IDLE, GRANT, TURN (TURN exists only with the optional feature).
- Arbitration:
  - Winner = first i with req[i]=1, scanning ptr, ptr+1, ... mod 4.
- IDLE:
  - If req!=0, the next edge enters GRANT with cur=winner. Outputs: gnt=onehot(cur), {S1,S0}=cur, E=1, busy=1, cnt=1.
  - Latency from req rising to gnt: 1 clock.
  - If req=0, stay in IDLE with E=0, gnt=0, busy=0. S1/S0 hold the last granted index.
- GRANT, release (req[cur]=0 at an edge):
  - ptr <= cur+1 mod 4; gnt[cur] drops on that edge.
  - Without the turnaround: if other requests are pending, the new winner is granted on the same edge (back-to-back, zero dead cycles). Otherwise go to IDLE.
- GRANT, preempt:
  - Triggered when MAX_HOLD!=0, req[cur]=1, cnt==MAX_HOLD, and (req & ~onehot(cur))!=0.
  - Handled exactly like a release: ptr <= cur+1 and cur loses the grant.
  - The preempted requester keeps req high and is re-served in round-robin order.
- GRANT, continue:
  - Otherwise stay; cnt <= cnt+1, saturating at MAX_HOLD.
  - If nobody else requests, a requester at the limit keeps its grant indefinitely.
- Simultaneous release and preempt in one cycle: treated as a release.
- New requests arriving during GRANT never disturb the current grant except through the preempt rule.
- Output invariants:
  - gnt is always zero or one-hot.
  - E=1 iff gnt!=0.
  - When E=1, {S1,S0} equals the index of the set gnt bit.
  - busy == E.
- All outputs are registered; no combinational path from req to outputs.

Optional Feature:
- Macro: MUX_4X1_ARB_TURNAROUND_EN.
- Defined:
  - Every grant end (release or preempt) goes to TURN for exactly 1 cycle: E=0, gnt=0000, busy=0.
  - S1/S0 keep the old index during TURN, so tri-state drivers never overlap.
  - TURN then goes to GRANT (winner evaluated at that edge using the updated ptr), or to IDLE if req=0.
  - Handover gap is 1 dead cycle.
- Undefined:
  - TURN state is not present; handover is back-to-back as described under Behaviour.

Test Plan:
- Reset then single request: rst=1 for 2 cycles, req=0100 → one cycle later gnt=0100, S1=1, S0=0, E=1. Drop req → gnt=0000, E=0 at the next edge.
- Round-robin fairness: req=1111 held for each tenure, every requester releases after 3 granted cycles → grant order 0,1,2,3,0. {S1,S0} tracks 00,01,10,11,00.
- Preemption with MAX_HOLD=4: req0 held continuously, req2 asserted at cycle 2 → gnt=0001 for exactly 4 cycles, then gnt=0100. Requester 0 is re-granted after requester 2 releases.
- Saturation without contention, MAX_HOLD=4: only req1 high for 20 cycles → gnt=0010 for all 20 cycles, no preemption, cnt stays at 4.
- Mid-operation reset: during gnt=1000, assert rst for 1 cycle → next edge gnt=0000, E=0, S1=S0=0, ptr=0. With req=1001 afterwards, requester 0 wins first.
- Turnaround, with MUX_4X1_ARB_TURNAROUND_EN: req=0011, requester 0 releases → exactly 1 cycle of E=0, gnt=0000, then gnt=0010. Without the macro, gnt goes directly 0001 → 0010.
